// File: rtl/sockit_spi_sff_if.sv
// Request/grant streaming interface of the single-clock SPI FIFO, with
// fill-level status and the almost-empty/almost-full thresholds.
interface sockit_spi_sff_if #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DW-1:0] sfi_dat;
   logic          sfi_req;
   logic          sfi_grt;
   logic [DW-1:0] sfo_dat;
   logic          sfo_req;
   logic          sfo_grt;
   logic [CW-1:0] thr_aem;
   logic [CW-1:0] thr_afl;
   logic [CW-1:0] lvl;
   logic          aem;
   logic          afl;

   modport master (
      output sfi_dat, sfi_req, sfo_grt, thr_aem, thr_afl,
      input  sfi_grt, sfo_dat, sfo_req, lvl, aem, afl
   );

   modport slave (
      input  sfi_dat, sfi_req, sfo_grt, thr_aem, thr_afl,
      output sfi_grt, sfo_dat, sfo_req, lvl, aem, afl
   );
endinterface

// File: rtl/sockit_spi_sff.sv
// Single-clock FIFO of arbitrary depth with registered grant/request,
// fill level, programmable almost-empty/almost-full flags and a synchronous clear.
module sockit_spi_sff #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input logic             clk,
   input logic             rst,
   input logic             clr,
   sockit_spi_sff_if.slave sf
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wpt_q, wpt_d;
   logic [PW-1:0] rpt_q, rpt_d;
   logic [CW-1:0] lvl_q, lvl_d;
   logic          grt_q, req_q, aem_q, afl_q;
   logic          sfi_trn, sfo_trn;

   assign sfi_trn = sf.sfi_req & grt_q;
   assign sfo_trn = req_q & sf.sfo_grt;

   always_comb begin
      wpt_d = wpt_q;
      rpt_d = rpt_q;
      lvl_d = lvl_q;
      if (clr) begin
         wpt_d = '0;
         rpt_d = '0;
         lvl_d = '0;
      end else begin
         // Explicit wrap: DEPTH need not be a power of two.
         if (sfi_trn) wpt_d = (wpt_q == PW'(DEPTH - 1)) ? '0 : wpt_q + PW'(1);
         if (sfo_trn) rpt_d = (rpt_q == PW'(DEPTH - 1)) ? '0 : rpt_q + PW'(1);
         case ({sfi_trn, sfo_trn})
            2'b10:   lvl_d = lvl_q + CW'(1);
            2'b01:   lvl_d = lvl_q - CW'(1);
            default: lvl_d = lvl_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sfi_trn) mem[wpt_q] <= sf.sfi_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wpt_q <= '0;
         rpt_q <= '0;
         lvl_q <= '0;
         grt_q <= 1'b1;
         req_q <= 1'b0;
         aem_q <= 1'b1;
         afl_q <= (sf.thr_afl == '0);
      end else begin
         wpt_q <= wpt_d;
         rpt_q <= rpt_d;
         lvl_q <= lvl_d;
         grt_q <= (lvl_d != CW'(DEPTH));
         req_q <= (lvl_d != '0);
         aem_q <= (lvl_d <= sf.thr_aem);
         afl_q <= (lvl_d >= sf.thr_afl);
      end
   end

   assign sf.sfi_grt = grt_q;
   assign sf.sfo_req = req_q;
   assign sf.sfo_dat = mem[rpt_q];
   assign sf.lvl     = lvl_q;
   assign sf.aem     = aem_q;
   assign sf.afl     = afl_q;
endmodule
